// File: rtl/ticks_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// A start/busy/done handshake lets the LCD side request a fresh snapshot of the tick count.
module ticks_bcd_converter #(
  parameter int IN_W    = 17,
  parameter int DIGITS  = 6,
  parameter int MAX_VAL = 96000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_conv,
  input  logic [IN_W-1:0]       ticks_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  over
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int WRK_W = BCD_W + IN_W;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_r;
  logic [WRK_W-1:0]   work_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               over_next_r;
  logic [WRK_W-1:0]   adj_s;
  logic [WRK_W-1:0]   shifted_s;

  // Each nibble of 5..9 gets +3 so the following shift carries into the next digit; max sum is 12.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = acc[4*i +: 4];
      end
    end
    return res;
  endfunction

  // One double-dabble step: adjust the BCD field, then shift the whole working register.
  always_comb begin
    adj_s     = {add3_nibbles(work_r[WRK_W-1:IN_W]), work_r[IN_W-1:0]};
    shifted_s = {adj_s[WRK_W-2:0], 1'b0};
  end

  // Handshake FSM with the working register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      work_r      <= '0;
      cnt_r       <= '0;
      over_next_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd         <= '0;
      over        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start_conv) begin
            work_r      <= {{BCD_W{1'b0}}, ticks_in};
            cnt_r       <= '0;
            over_next_r <= (32'(ticks_in) > 32'(MAX_VAL));
            busy        <= 1'b1;
            state_r     <= SHIFT;
          end
        end
        SHIFT: begin
          work_r <= shifted_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          // Last input bit consumed: publish and return to idle; a start seen here is dropped.
          if (cnt_r == LAST_BIT) begin
            bcd     <= shifted_s[WRK_W-1:IN_W];
            over    <= over_next_r;
            done    <= 1'b1;
            busy    <= 1'b0;
            cnt_r   <= '0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ticks_bcd_converter.sv
// Directed bench for ticks_bcd_converter: vector table plus handshake and reset corner sequences.
module tb_ticks_bcd_converter;

  logic        clk;
  logic        rst_n;
  logic        start_conv;
  logic [16:0] ticks_in;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic        over;

  int tests;
  int fails;

  ticks_bcd_converter #(.IN_W(17), .DIGITS(6), .MAX_VAL(96000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_conv (start_conv),
    .ticks_in   (ticks_in),
    .busy       (busy),
    .done       (done),
    .bcd        (bcd),
    .over       (over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] ticks;
    logic [23:0] exp_bcd;
    logic        exp_over;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one sample, then wait (bounded) for done; report latency and busy-high cycles.
  task automatic run_conv(input logic [16:0] t, output int lat, output int busy_cnt);
    @(negedge clk);
    ticks_in   = t;
    start_conv = 1'b1;
    @(posedge clk);
    #1;
    start_conv = 1'b0;
    busy_cnt   = busy ? 1 : 0;
    lat        = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  int lat, bcnt, dcnt, first_done;
  int dtimes[3];

  initial begin
    tests      = 0;
    fails      = 0;
    rst_n      = 1'b0;
    start_conv = 1'b0;
    ticks_in   = 17'd0;

    vecs[0] = '{17'd0,      24'h000000, 1'b0};
    vecs[1] = '{17'd96000,  24'h096000, 1'b0};
    vecs[2] = '{17'd96001,  24'h096001, 1'b1};
    vecs[3] = '{17'd131071, 24'h131071, 1'b1};
    vecs[4] = '{17'd12345,  24'h012345, 1'b0};
    vecs[5] = '{17'd9,      24'h000009, 1'b0};
    vecs[6] = '{17'd99999,  24'h099999, 1'b1};
    vecs[7] = '{17'd10,     24'h000010, 1'b0};
    vecs[8] = '{17'd50505,  24'h050505, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd",  32'(bcd),  32'd0);
    check("reset_over", 32'(over), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].ticks, lat, bcnt);
      check("vec_bcd",     32'(bcd),  32'(vecs[i].exp_bcd));
      check("vec_over",    32'(over), 32'(vecs[i].exp_over));
      check("vec_latency", 32'(lat),  32'd17);
      check("vec_busy",    32'(bcnt), 32'd17);
      @(posedge clk);
      #1;
      check("vec_done_pulse", 32'(done), 32'd0);
    end

    // Starts at +3 and at the finishing edge +17 must both be dropped.
    @(negedge clk);
    ticks_in   = 17'd5;
    start_conv = 1'b1;
    @(posedge clk);
    #1;
    start_conv = 1'b0;
    dcnt       = 0;
    first_done = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start_conv = (k == 3 || k == 17);
      ticks_in   = (k == 3 || k == 17) ? 17'd777 : 17'd5;
      @(posedge clk);
      #1;
      if (done) begin
        dcnt++;
        if (first_done == 0) first_done = k;
      end
    end
    start_conv = 1'b0;
    check("ignore_done_count", 32'(dcnt),       32'd1);
    check("ignore_done_time",  32'(first_done), 32'd17);
    check("ignore_bcd",        32'(bcd),        32'h000005);

    // Continuous start: back-to-back conversions every 18 clocks.
    @(negedge clk);
    ticks_in   = 17'd5;
    start_conv = 1'b1;
    dcnt       = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (dcnt < 3) dtimes[dcnt] = k;
        dcnt++;
      end
    end
    @(negedge clk);
    start_conv = 1'b0;
    check("hold_done_count", 32'(dcnt), 32'd3);
    check("hold_period_1",   32'(dtimes[1] - dtimes[0]), 32'd18);
    check("hold_period_2",   32'(dtimes[2] - dtimes[1]), 32'd18);
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      @(posedge clk);
      #1;
    end
    check("hold_drain", 32'(busy), 32'd0);

    // Input changes during the conversion must not leak into the result.
    @(negedge clk);
    ticks_in   = 17'd4242;
    start_conv = 1'b1;
    @(posedge clk);
    #1;
    start_conv = 1'b0;
    ticks_in   = 17'd9;
    lat        = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("hold_input_latency", 32'(lat), 32'd17);
    check("hold_input_bcd",     32'(bcd), 32'h004242);

    // Asynchronous reset in the middle of a conversion.
    run_conv(17'd12345, lat, bcnt);
    check("pre_reset_bcd", 32'(bcd), 32'h012345);
    @(negedge clk);
    ticks_in   = 17'd777;
    start_conv = 1'b1;
    @(posedge clk);
    #1;
    start_conv = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd",  32'(bcd),  32'd0);
    check("abort_over", 32'(over), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt  = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) dcnt++;
    end
    check("post_reset_quiet", 32'(dcnt), 32'd0);
    run_conv(17'd42, lat, bcnt);
    check("post_reset_bcd",     32'(bcd),  32'h000042);
    check("post_reset_over",    32'(over), 32'd0);
    check("post_reset_latency", 32'(lat),  32'd17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
